// File: rtl/derevaluate_controller_pkg.sv
// Shared definitions for the revaluate/derevaluate stage pair: state codes,
// slice geometry and the chi / inverse-chi row functions.
package derevaluate_controller_pkg;

   localparam int SLICES  = 64;
   localparam int LANES   = 25;
   localparam int ROW_W   = 5;
   localparam int ROWS    = LANES / ROW_W;
   localparam int SLICE_W = $clog2(SLICES);
   localparam int BIT_W   = $clog2(LANES);

   localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(SLICES - 1);
   localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(LANES - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ARM   = 3'd1;
   localparam logic [2:0] ST_READ  = 3'd2;
   localparam logic [2:0] ST_LOAD  = 3'd3;
   localparam logic [2:0] ST_WRITE = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   function automatic logic [ROW_W-1:0] chi5(input logic [ROW_W-1:0] a);
      logic [ROW_W-1:0] b;
      for (int x = 0; x < ROW_W; x++)
         b[x] = a[x] ^ (~a[(x + 1) % ROW_W] & a[(x + 2) % ROW_W]);
      return b;
   endfunction

   // chi is a bijection on 5 bits, so searching its image builds the inverse table
   function automatic logic [ROW_W-1:0] inv_chi5(input logic [ROW_W-1:0] b);
      logic [ROW_W-1:0] a;
      a = '0;
      for (int c = 0; c < (1 << ROW_W); c++)
         if (chi5(ROW_W'(c)) == b)
            a = ROW_W'(c);
      return a;
   endfunction

endpackage

// File: rtl/derevaluate_controller_inv_chi_row.sv
// Combinational 32-entry inverse-chi lookup for one 5-bit row.
module inv_chi_row
   import derevaluate_controller_pkg::*;
(
   input  logic [ROW_W-1:0] row_in,
   output logic [ROW_W-1:0] row_out
);

   assign row_out = inv_chi5(row_in);

endmodule

// File: rtl/derevaluate_controller.sv
// Derevaluate stage: reads each slice, applies inverse chi to all rows and
// streams the result out one lane bit per cycle.
//
// state | meaning
// IDLE  | waiting for start
// ARM   | start seen, waiting for it to fall; slice counter cleared
// READ  | slice read strobe issued
// LOAD  | registered slice data arrives, inverse chi captured
// WRITE | one result bit written per cycle, 25 per slice
// DONE  | one-cycle ready pulse
module derevaluate_controller
   import derevaluate_controller_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               rd_en,
   output logic [SLICE_W-1:0] rd_addr,
   input  logic [LANES-1:0]   rd_data,
   output logic               wr_en,
   output logic [SLICE_W-1:0] wr_addr,
   output logic [BIT_W-1:0]   wr_idx,
   output logic               wr_data,
   output logic               busy,
   output logic               ready
);

   logic [2:0]         state_q;
   logic [2:0]         state_d;
   logic [SLICE_W-1:0] slice_q;
   logic [BIT_W-1:0]   bit_q;
   logic [LANES-1:0]   slice_reg;
   logic [LANES-1:0]   inv_data;

   for (genvar y = 0; y < ROWS; y++) begin : g_row
      inv_chi_row u_row (
         .row_in  (rd_data[ROW_W*y +: ROW_W]),
         .row_out (inv_data[ROW_W*y +: ROW_W])
      );
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_ARM;
         ST_ARM:   if (!start) state_d = ST_READ;
         ST_READ:  state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_WRITE;
         ST_WRITE: begin
            if (bit_q == LAST_BIT)
               state_d = (slice_q == LAST_SLICE) ? ST_DONE : ST_READ;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         slice_q   <= '0;
         bit_q     <= '0;
         slice_reg <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_ARM:  slice_q <= '0;
            ST_LOAD: begin
               slice_reg <= inv_data;
               bit_q     <= '0;
            end
            ST_WRITE: begin
               bit_q <= bit_q + 1'b1;
               // last slice holds at 63 so the address never wraps within a run
               if (bit_q == LAST_BIT && slice_q != LAST_SLICE)
                  slice_q <= slice_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign rd_en   = (state_q == ST_READ);
   assign wr_en   = (state_q == ST_WRITE);
   assign ready   = (state_q == ST_DONE);
   assign busy    = (state_q != ST_IDLE);
   assign rd_addr = slice_q;
   assign wr_addr = slice_q;
   assign wr_idx  = bit_q;
   assign wr_data = slice_reg[bit_q];

endmodule

// File: tb/tb_derevaluate_controller.sv
// Directed bench: encodes known states with chi, runs them through the
// controller and checks timing, write ordering and recovered data.
module tb_derevaluate_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic [24:0] rd_data;
   logic        wr_en;
   logic [5:0]  wr_addr;
   logic [4:0]  wr_idx;
   logic        wr_data;
   logic        busy;
   logic        ready;

   derevaluate_controller dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .busy    (busy),
      .ready   (ready)
   );

   always #5 clk = ~clk;

   logic [24:0]   mem  [64];
   logic [24:0]   orig [64];
   logic [1599:0] outv;
   logic [1599:0] expv;
   int wr_cnt;
   int order_err;
   int ready_cnt;
   int n_cmp = 0;
   int n_bad = 0;

   always @(posedge clk)
      if (rd_en) rd_data <= mem[rd_addr];

   always @(negedge clk) begin
      if (wr_en) begin
         if (int'(wr_addr) != wr_cnt / 25 || int'(wr_idx) != wr_cnt % 25)
            order_err++;
         if (wr_idx < 5'd25)
            outv[int'(wr_addr) * 25 + int'(wr_idx)] = wr_data;
         wr_cnt++;
      end
      if (ready) ready_cnt++;
   end

   function automatic logic [4:0] chi_ref(input logic [4:0] a);
      logic [4:0] b;
      b[0] = a[0] ^ (~a[1] & a[2]);
      b[1] = a[1] ^ (~a[2] & a[3]);
      b[2] = a[2] ^ (~a[3] & a[4]);
      b[3] = a[3] ^ (~a[4] & a[0]);
      b[4] = a[4] ^ (~a[0] & a[1]);
      return b;
   endfunction

   function automatic logic [24:0] chi_slice(input logic [24:0] s);
      logic [24:0] r;
      for (int y = 0; y < 5; y++)
         r[5*y +: 5] = chi_ref(s[5*y +: 5]);
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: zeros, 1: ones, 2: slice 5 row0 = 1, 3: random
   task automatic load_state(input int mode);
      for (int s = 0; s < 64; s++) begin
         case (mode)
            0: orig[s] = 25'h0;
            1: orig[s] = 25'h1FFFFFF;
            2: orig[s] = (s == 5) ? 25'h0000001 : 25'h0;
            default: orig[s] = 25'($urandom);
         endcase
         mem[s] = chi_slice(orig[s]);
         expv[s*25 +: 25] = orig[s];
      end
   endtask

   task automatic run(input string name, input int hold, input int pulse_slice, input int abort_slice);
      int  cyc;
      int  rdy_cyc;
      int  first_rd;
      int  nd;
      logic busy1;
      bit  aborted;
      @(negedge clk);
      wr_cnt    = 0;
      order_err = 0;
      ready_cnt = 0;
      outv      = 'x;
      start     = 1'b1;
      cyc       = 0;
      rdy_cyc   = -1;
      first_rd  = -1;
      busy1     = 1'b0;
      aborted   = 1'b0;
      while (rdy_cyc < 0 && !aborted && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (cyc == hold) start = 1'b0;
         if (cyc == 1) busy1 = busy;
         if (rd_en && first_rd < 0) first_rd = cyc;
         if (ready) rdy_cyc = cyc;
         if (pulse_slice >= 0) begin
            if (start && cyc > hold) start = 1'b0;
            if (wr_en && int'(wr_addr) == pulse_slice && wr_idx == 5'd7) start = 1'b1;
         end
         if (abort_slice >= 0 && wr_en && int'(wr_addr) == abort_slice && wr_idx == 5'd3) begin
            #2 rst = 1'b0;
            #1 check({name, "/abort_outs"},
                     64'({rd_en, rd_addr, wr_en, wr_addr, wr_idx, wr_data, busy, ready}), 64'd0);
            aborted = 1'b1;
         end
      end
      start = 1'b0;
      if (aborted) begin
         @(negedge clk);
         rst = 1'b1;
         repeat (3) @(negedge clk);
         check({name, "/abort_no_ready"}, 64'(ready_cnt), 64'd0);
         check({name, "/abort_idle"}, 64'(busy), 64'd0);
         return;
      end
      repeat (3) @(negedge clk);
      nd = 0;
      for (int i = 0; i < 1600; i++)
         if (outv[i] !== expv[i]) nd++;
      check({name, "/ready_cycle"}, 64'(rdy_cyc), 64'(1729 + hold));
      check({name, "/ready_count"}, 64'(ready_cnt), 64'd1);
      check({name, "/write_count"}, 64'(wr_cnt), 64'd1600);
      check({name, "/write_order"}, 64'(order_err), 64'd0);
      check({name, "/first_read"}, 64'(first_rd), 64'(hold + 1));
      check({name, "/busy_arm"}, 64'(busy1), 64'd1);
      check({name, "/busy_after"}, 64'(busy), 64'd0);
      check({name, "/data_bits_wrong"}, 64'(nd), 64'd0);
   endtask

   initial begin
      rst     = 1'b0;
      start   = 1'b0;
      rd_data = '0;
      for (int s = 0; s < 64; s++) mem[s] = '0;
      #12;
      check("reset_outs",
            64'({rd_en, rd_addr, wr_en, wr_addr, wr_idx, wr_data, busy, ready}), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      load_state(0);
      run("zero", 1, -1, -1);

      load_state(1);
      run("ones", 1, -1, -1);

      load_state(2);
      run("slice5", 1, -1, -1);
      check("slice5/bit0", 64'(outv[125]), 64'd1);
      check("slice5/bit1", 64'(outv[126]), 64'd0);

      load_state(3);
      run("hold10", 10, -1, -1);

      load_state(3);
      run("pulse30", 1, 30, -1);

      load_state(3);
      run("abort12", 1, -1, 12);

      load_state(3);
      run("after_abort", 1, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
